// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the APB PS/2 mouse peripheral.
// - Register word offsets (paddr[3:2]) for CTRL / STATUS / DATA / CLEAR.
// - Bit positions of the STATUS register flags.
// - Packet layout held in the FIFO and the receiver frame-state encoding.
package ps2_mouse_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    localparam int ST_EMPTY    = 8;
    localparam int ST_FULL     = 9;
    localparam int ST_OVERFLOW = 16;
    localparam int ST_PARITY   = 17;
    localparam int ST_FRAME    = 18;
    localparam int ST_TIMEOUT  = 19;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] dx;
        logic [7:0] dy;
    } mouse_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver.
// Synchronises the PS/2 clock/data pair, detects falling edges of the PS/2
// clock, and runs the start/8 data/odd parity/stop frame FSM. A watchdog
// aborts a stalled frame (or a stalled packet, via busy_i) after
// TIMEOUT_CYCLES clk_i cycles without a PS/2 falling edge.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   ps2_clk_i/data_i    asynchronous PS/2 lines (idle high)
//   busy_i              packet assembly is mid-packet (arms the watchdog)
//   byte_valid_o/byte_o one-cycle pulse with a correctly framed byte
//   parity_err_o, frame_err_o, timeout_o   one-cycle error pulses
//   state_o             current frame FSM state (debug)
module ps2_rx
    import ps2_mouse_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       busy_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       timeout_o,
    output rx_state_e  state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, fall;

    rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          tmo_pulse_q, tmo_pulse_d;
    logic          armed;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    // Falling edge: synchronised clock was high last cycle and is low now.
    assign fall   = clk_prev_q & ~clk_s;
    assign armed  = (state_q != IDLE) | busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        valid_d     = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        tmo_pulse_d = 1'b0;
        if (fall) begin
            // Every edge reloads the watchdog, so an edge always wins over expiry.
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    ferr_d  = ~data_s;
                    perr_d  = ~(^{shift_q, par_q});
                    valid_d = data_s & (^{shift_q, par_q});
                end
                default: state_d = IDLE;
            endcase
        end else if (!armed) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d       = '0;
            state_d     = IDLE;
            tmo_pulse_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign timeout_o    = tmo_pulse_q;
    assign state_o      = state_q;

endmodule

// File: rtl/apb_ps2_mouse.sv
// APB PS/2 mouse peripheral.
// Assembles 3-byte mouse packets from the PS/2 receiver, buffers them in a
// FIFO and exposes CTRL / STATUS / DATA(pop) / CLEAR registers over APB.
// irq_o is a registered level: irq_en & FIFO not empty.
// Ports:
//   clk_i, rst_i                   system clock, synchronous active-high reset
//   paddr_i..penable_i             APB request (zero wait states)
//   prdata_o, pready_o, pslverr_o  APB response
//   ps2_clk_i, ps2_data_i          PS/2 lines
//   irq_o                          level interrupt
// APB handshake: an access completes in the cycle where psel_i & penable_i
// are both high (pready_o is always 1); writes and DATA pops take effect at
// the clock edge that ends that cycle, and only when the address is legal.
module apb_ps2_mouse
    import ps2_mouse_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic                      ps2_clk_i,
    input  logic                      ps2_data_i,
    output logic                      irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic       rx_valid, rx_perr, rx_ferr, rx_tmo;
    logic [7:0] rx_byte;
    rx_state_e  rx_state;

    logic [1:0]  ctrl_q;         // {irq_en, enable}
    logic [3:0]  sticky_q, sticky_d;  // {timeout, frame, parity, overflow}
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    mouse_pkt_t  fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic        irq_q;

    logic        addr_err, wr, rd, empty, full, pop, push, push_ok, bad_b0;
    logic [1:0]  sel;
    logic [3:0]  set_flags, clr_flags;
    logic [31:0] status_word;
    mouse_pkt_t  head, new_pkt;
    logic        unused_bits;

    ps2_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .busy_i       (idx_q != 2'd0),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .parity_err_o (rx_perr),
        .frame_err_o  (rx_ferr),
        .timeout_o    (rx_tmo),
        .state_o      (rx_state)
    );

    assign addr_err  = |paddr_i[APB_ADDR_WIDTH-1:4];
    assign sel       = paddr_i[3:2];
    assign wr        = psel_i & penable_i & pwrite_i & ~addr_err;
    assign rd        = psel_i & penable_i & ~pwrite_i & ~addr_err;
    assign pready_o  = 1'b1;
    assign pslverr_o = psel_i & penable_i & addr_err;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = rd & (sel == REG_DATA) & ~empty;
    assign head    = fifo_q[rd_ptr_q];
    assign new_pkt = '{status: b0_q, dx: b1_q, dy: rx_byte};
    // A full FIFO still accepts a packet when the head leaves on the same edge.
    assign push_ok = push & (~full | pop);

    // Packet assembly. Receiver aborts reset the byte index regardless of
    // enable; with enable low, good bytes are swallowed and nothing is flagged.
    always_comb begin
        idx_d  = idx_q;
        b0_d   = b0_q;
        b1_d   = b1_q;
        push   = 1'b0;
        bad_b0 = 1'b0;
        if (rx_tmo || rx_perr || rx_ferr) begin
            idx_d = 2'd0;
        end else if (rx_valid) begin
            if (!ctrl_q[0]) begin
                idx_d = 2'd0;
            end else begin
                case (idx_q)
                    2'd0: begin
                        // Bit3 is always set in a status byte; anything else
                        // means we are out of step, so stay at index 0.
                        if (rx_byte[3]) begin
                            b0_d  = rx_byte;
                            idx_d = 2'd1;
                        end else begin
                            bad_b0 = 1'b1;
                        end
                    end
                    2'd1: begin
                        b1_d  = rx_byte;
                        idx_d = 2'd2;
                    end
                    default: begin
                        push  = 1'b1;
                        idx_d = 2'd0;
                    end
                endcase
            end
        end
    end

    assign set_flags = {ctrl_q[0] & rx_tmo,
                        ctrl_q[0] & (rx_ferr | bad_b0),
                        ctrl_q[0] & rx_perr,
                        push & ~push_ok};
    assign clr_flags = (wr && sel == REG_CLEAR) ? pwdata_i[19:16] : 4'd0;
    assign sticky_d  = (sticky_q & ~clr_flags) | set_flags;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            sticky_q <= '0;
            idx_q    <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && sel == REG_CTRL) ctrl_q <= pwdata_i[1:0];
            sticky_q <= sticky_d;
            idx_q    <= idx_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            irq_q <= ctrl_q[1] & ~empty;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_q[wr_ptr_q] <= new_pkt;
    end

    always_comb begin
        status_word              = '0;
        status_word[3:0]         = 4'(count_q);
        status_word[ST_EMPTY]    = empty;
        status_word[ST_FULL]     = full;
        status_word[ST_OVERFLOW] = sticky_q[0];
        status_word[ST_PARITY]   = sticky_q[1];
        status_word[ST_FRAME]    = sticky_q[2];
        status_word[ST_TIMEOUT]  = sticky_q[3];
    end

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i && !addr_err) begin
            case (sel)
                REG_CTRL:   prdata_o = {30'd0, ctrl_q};
                REG_STATUS: prdata_o = status_word;
                REG_DATA:   prdata_o = empty ? 32'd0 : {8'h00, head};
                default:    prdata_o = '0;
            endcase
        end
    end

    assign irq_o = irq_q;

    assign unused_bits = ^{paddr_i[1:0], pwdata_i[31:20], pwdata_i[15:2], rx_state};

endmodule
